// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one uart_tx byte transmitter
// among NREQ requesters. The grant is held for a whole packet, so packets
// from different requesters never interleave. An optional timeout revokes
// the grant from an owner that stays idle in the middle of a packet.
module uart_tx_arb #(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned LOCK_TIMEOUT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_bi,
    input  logic [NREQ-1:0]   last_bi,
    input  logic [8*NREQ-1:0] data_bi,
    output logic [NREQ-1:0]   ack_bo,
    output logic [NREQ-1:0]   grant_bo,
    input  logic              locked_i,
    output logic              tx_start_o,
    output logic [7:0]        tx_data_bo,
    input  logic              tx_done_tick_i,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] own_q;
    logic          last_q;
    logic [31:0]   tmo_cnt;

    logic [IW-1:0] arb_sel;
    logic          arb_hit;
    int unsigned   idx;
    logic [7:0]    bytes [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_bytes
        assign bytes[g] = data_bi[8*g +: 8];
    end

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] k);
        logic [NREQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: first requesting index after ptr, wrapping modulo NREQ.
    always_comb begin
        arb_hit = 1'b0;
        arb_sel = '0;
        idx     = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!arb_hit && req_bi[idx[IW-1:0]]) begin
                arb_hit = 1'b1;
                arb_sel = idx[IW-1:0];
            end
        end
    end

    // Sequencer: launch one byte, wait for its done tick, hold grant mid-packet.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            ptr        <= IW'(NREQ - 1);
            own_q      <= '0;
            last_q     <= 1'b0;
            tmo_cnt    <= '0;
            ack_bo     <= '0;
            grant_bo   <= '0;
            tx_start_o <= 1'b0;
            tx_data_bo <= '0;
            busy_o     <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            tx_start_o <= 1'b0;
            ack_bo     <= '0;
            timeout_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (locked_i && arb_hit) begin
                        own_q      <= arb_sel;
                        tx_data_bo <= bytes[arb_sel];
                        last_q     <= last_bi[arb_sel];
                        grant_bo   <= onehot(arb_sel);
                        ack_bo     <= onehot(arb_sel);
                        tx_start_o <= 1'b1;
                        busy_o     <= 1'b1;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tx_done_tick_i) begin
                        if (last_q) begin
                            grant_bo <= '0;
                            ptr      <= own_q;
                            busy_o   <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (req_bi[own_q] && locked_i) begin
                        tx_data_bo <= bytes[own_q];
                        last_q     <= last_bi[own_q];
                        ack_bo     <= onehot(own_q);
                        tx_start_o <= 1'b1;
                        state      <= ST_WAIT;
                    end else if (LOCK_TIMEOUT != 0) begin
                        if (tmo_cnt == 32'(LOCK_TIMEOUT - 1)) begin
                            grant_bo  <= '0;
                            ptr       <= own_q;
                            timeout_o <= 1'b1;
                            busy_o    <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 32'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: scoreboard of expected launches
// (owner one-hot + byte) checked whenever tx_start_o pulses, plus a
// simple uart_tx responder that returns a done tick after a fixed delay.
module tb_uart_tx_arb;

    localparam int unsigned NREQ         = 2;
    localparam int unsigned LOCK_TIMEOUT = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NREQ-1:0]   req_bi;
    logic [NREQ-1:0]   last_bi;
    logic [8*NREQ-1:0] data_bi;
    logic [NREQ-1:0]   ack_bo;
    logic [NREQ-1:0]   grant_bo;
    logic              locked_i;
    logic              tx_start_o;
    logic [7:0]        tx_data_bo;
    logic              tx_done_tick_i;
    logic              busy_o;
    logic              timeout_o;

    uart_tx_arb #(.NREQ(NREQ), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_bi        (req_bi),
        .last_bi       (last_bi),
        .data_bi       (data_bi),
        .ack_bo        (ack_bo),
        .grant_bo      (grant_bo),
        .locked_i      (locked_i),
        .tx_start_o    (tx_start_o),
        .tx_data_bo    (tx_data_bo),
        .tx_done_tick_i(tx_done_tick_i),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0] grant;
        logic [7:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks    = 0;
    int          failures  = 0;
    int          start_cnt = 0;
    int unsigned done_lat  = 10;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [7:0] d);
        exp_t e;
        e.grant = g;
        e.data  = d;
        sb.push_back(e);
    endtask

    // Scoreboard: every launch must match the next expected owner and byte.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (tx_start_o === 1'b1) begin
                start_cnt++;
                if (sb.size() == 0) begin
                    check("start_with_empty_scoreboard", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("tx_data", 32'(tx_data_bo), 32'(e.data));
                    check("ack",     32'(ack_bo),     32'(e.grant));
                    check("grant",   32'(grant_bo),   32'(e.grant));
                end
            end
        end
    end

    // uart_tx stand-in: one done tick done_lat cycles after each start.
    initial begin
        tx_done_tick_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (tx_start_o === 1'b1) begin
                repeat (done_lat) @(negedge clk_i);
                tx_done_tick_i = 1'b1;
                @(negedge clk_i);
                tx_done_tick_i = 1'b0;
            end
        end
    end

    task automatic wait_start(input string tag, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            n++;
            if (tx_start_o === 1'b1) return;
        end
        check({tag, "_start_timeout"}, 32'(tx_start_o), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i);
            if (tx_done_tick_i === 1'b1) begin
                #1;
                return;
            end
        end
        check({tag, "_done_timeout"}, 32'(tx_done_tick_i), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i    = 1'b1;
        req_bi   = '0;
        last_bi  = '0;
        data_bi  = '0;
        locked_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        int n;
        int tcyc;
        int base;

        rst_i    = 1'b1;
        req_bi   = '0;
        last_bi  = '0;
        data_bi  = '0;
        locked_i = 1'b0;

        // Reset state
        do_reset();
        check("rst_ack",     32'(ack_bo),     32'd0);
        check("rst_grant",   32'(grant_bo),   32'd0);
        check("rst_start",   32'(tx_start_o), 32'd0);
        check("rst_data",    32'(tx_data_bo), 32'd0);
        check("rst_busy",    32'(busy_o),     32'd0);
        check("rst_timeout", 32'(timeout_o),  32'd0);

        // 1: single-byte packet
        push(2'b01, 8'hA5);
        req_bi[0]     = 1'b1;
        last_bi[0]    = 1'b1;
        data_bi[7:0]  = 8'hA5;
        wait_start("t1", n);
        check("t1_latency", 32'(n), 32'd1);
        check("t1_busy", 32'(busy_o), 32'd1);
        req_bi[0] = 1'b0;
        wait_done("t1");
        check("t1_grant_clear", 32'(grant_bo), 32'd0);
        check("t1_busy_clear", 32'(busy_o), 32'd0);

        // 2: round-robin with both requesters held high
        do_reset();
        push(2'b01, 8'h11);
        push(2'b10, 8'h22);
        push(2'b01, 8'h11);
        push(2'b10, 8'h22);
        req_bi        = 2'b11;
        last_bi       = 2'b11;
        data_bi       = {8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            wait_start("t2", n);
            check("t2_gap", 32'(n), (i == 0) ? 32'd1 : 32'd2);
            if (i == 3) req_bi = '0;
            wait_done("t2");
            check("t2_grant_after_done", 32'(grant_bo), 32'd0);
        end

        // 3: three-byte packet from requester 0 must not be interrupted
        do_reset();
        push(2'b01, 8'h01);
        push(2'b01, 8'h02);
        push(2'b01, 8'h03);
        push(2'b10, 8'h55);
        req_bi  = 2'b11;
        last_bi = 2'b10;
        data_bi = {8'h55, 8'h01};
        wait_start("t3a", n);
        data_bi[7:0] = 8'h02;
        wait_done("t3a");
        check("t3_hold_grant", 32'(grant_bo), 32'd1);
        check("t3_hold_busy", 32'(busy_o), 32'd1);
        wait_start("t3b", n);
        check("t3_hold_gap", 32'(n), 32'd2);
        data_bi[7:0] = 8'h03;
        last_bi[0]   = 1'b1;
        wait_done("t3b");
        check("t3_hold_grant2", 32'(grant_bo), 32'd1);
        wait_start("t3c", n);
        req_bi[0] = 1'b0;
        wait_done("t3c");
        check("t3_grant_release", 32'(grant_bo), 32'd0);
        wait_start("t3d", n);
        req_bi[1] = 1'b0;
        wait_done("t3d");

        // 4: lock timeout after owner goes idle mid-packet
        do_reset();
        push(2'b01, 8'hAA);
        push(2'b10, 8'h55);
        req_bi  = 2'b11;
        last_bi = 2'b10;
        data_bi = {8'h55, 8'hAA};
        wait_start("t4a", n);
        req_bi[0] = 1'b0;
        wait_done("t4a");
        tcyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_i);
            #1;
            if (timeout_o === 1'b1) begin
                tcyc = i;
                break;
            end
        end
        check("t4_timeout_cycles", 32'(tcyc), 32'd16);
        check("t4_grant_revoked", 32'(grant_bo), 32'd0);
        @(posedge clk_i);
        #1;
        check("t4_timeout_width", 32'(timeout_o), 32'd0);
        wait_start("t4b", n);
        req_bi[1] = 1'b0;
        wait_done("t4b");

        // 5: no launch while the baud generator is unlocked
        do_reset();
        push(2'b01, 8'h3C);
        locked_i     = 1'b0;
        req_bi[0]    = 1'b1;
        last_bi[0]   = 1'b1;
        data_bi[7:0] = 8'h3C;
        base = start_cnt;
        repeat (50) @(negedge clk_i);
        check("t5_no_start_unlocked", 32'(start_cnt - base), 32'd0);
        locked_i = 1'b1;
        wait_start("t5", n);
        check("t5_latency", 32'(n), 32'd1);
        req_bi[0] = 1'b0;
        wait_done("t5");

        // 6: reset in ST_WAIT; the stray done tick afterwards is ignored
        do_reset();
        push(2'b01, 8'h77);
        req_bi[0]    = 1'b1;
        last_bi[0]   = 1'b0;
        data_bi[7:0] = 8'h77;
        wait_start("t6a", n);
        req_bi[0] = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("t6_ack",     32'(ack_bo),     32'd0);
        check("t6_grant",   32'(grant_bo),   32'd0);
        check("t6_start",   32'(tx_start_o), 32'd0);
        check("t6_data",    32'(tx_data_bo), 32'd0);
        check("t6_busy",    32'(busy_o),     32'd0);
        check("t6_timeout", 32'(timeout_o),  32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        base = start_cnt;
        repeat (20) @(negedge clk_i);
        check("t6_no_start_after_stray_done", 32'(start_cnt - base), 32'd0);
        check("t6_no_ack", 32'(ack_bo), 32'd0);
        push(2'b01, 8'h99);
        req_bi  = 2'b11;
        last_bi = 2'b11;
        data_bi = {8'h66, 8'h99};
        wait_start("t6b", n);
        check("t6_latency", 32'(n), 32'd1);
        req_bi = '0;
        wait_done("t6b");

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
